// File: rtl/taillight_pkg.sv
// Shared types and constants for the rear taillight sequencer.
package taillight_pkg;

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, LOFF, R1, R2, R3, ROFF, HON, HOFF
  } taillight_state_t;

  typedef enum logic [1:0] {
    NONE, LEFT, RIGHT, HAZ
  } req_t;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_1   = 3'b001;
  localparam logic [2:0] PAT_2   = 3'b011;
  localparam logic [2:0] PAT_ALL = 3'b111;

  function automatic taillight_state_t first_state(input req_t r);
    case (r)
      LEFT:    first_state = L1;
      RIGHT:   first_state = R1;
      HAZ:     first_state = HON;
      default: first_state = IDLE;
    endcase
  endfunction

  // Which request keeps a given state's sequence running.
  function automatic req_t seq_of(input taillight_state_t s);
    case (s)
      L1, L2, L3, LOFF: seq_of = LEFT;
      R1, R2, R3, ROFF: seq_of = RIGHT;
      HON, HOFF:        seq_of = HAZ;
      default:          seq_of = NONE;
    endcase
  endfunction

  function automatic taillight_state_t advance(input taillight_state_t s);
    case (s)
      L1:      advance = L2;
      L2:      advance = L3;
      L3:      advance = LOFF;
      LOFF:    advance = L1;
      R1:      advance = R2;
      R2:      advance = R3;
      R3:      advance = ROFF;
      ROFF:    advance = R1;
      HON:     advance = HOFF;
      HOFF:    advance = HON;
      default: advance = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step counter: counts 0..STEP_CYCLES-1, wraps, and flags the terminal count.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = $clog2(STEP_CYCLES);
  localparam logic [W-1:0] LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/taillight_sequencer.sv
// Prioritised turn/hazard/brake sequencer driving the left and right rear LED banks.
module taillight_sequencer import taillight_pkg::*; #(
  parameter int unsigned STEP_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brake,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       hazard,
  output logic [2:0] left_led,
  output logic [2:0] right_led,
  output logic       active
);

  taillight_state_t state, state_n;
  req_t             req;
  logic             tick;
  logic             clear;
  logic             brake_q;

  assign clear = (state == IDLE);

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    req = NONE;
    if (hazard || (turn_left && turn_right)) req = HAZ;
    else if (turn_left)                      req = LEFT;
    else if (turn_right)                     req = RIGHT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      brake_q <= 1'b0;
    end else begin
      state   <= state_n;
      brake_q <= brake;
    end
  end

  // Running sequences only re-evaluate the request on the step boundary.
  always_comb begin
    state_n = state;
    if (state == IDLE) begin
      state_n = first_state(req);
    end else if (tick) begin
      if (req == NONE)               state_n = IDLE;
      else if (req == seq_of(state)) state_n = advance(state);
      else                           state_n = first_state(req);
    end
  end

  always_comb begin
    left_led  = brake_q ? PAT_ALL : PAT_OFF;
    right_led = brake_q ? PAT_ALL : PAT_OFF;
    case (state)
      L1:   left_led  = PAT_1;
      L2:   left_led  = PAT_2;
      L3:   left_led  = PAT_ALL;
      LOFF: left_led  = PAT_OFF;
      R1:   right_led = PAT_1;
      R2:   right_led = PAT_2;
      R3:   right_led = PAT_ALL;
      ROFF: right_led = PAT_OFF;
      HON: begin
        left_led  = PAT_ALL;
        right_led = PAT_ALL;
      end
      HOFF: begin
        left_led  = PAT_OFF;
        right_led = PAT_OFF;
      end
      default: ;
    endcase
  end

  assign active = (state != IDLE);

endmodule
